lfsr_random_source: RTL
=======================

# lfsr_random_source

Parametrised Fibonacci LFSR random-number source with seed loading, zero-lockup protection, and range-limited draws over a valid/ready handshake. It generalises the reaction timer's single-shot 14-bit generator. The LFSR free-runs while enabled, so user timing such as a button press adds entropy. Consumers such as the random-delay counter request a value and receive one uniformly limited to `[0, RANGE_MAX]` by rejection sampling.

## Interface
- `WIDTH`, 14: LFSR state width, at least 3.
- `TAPS`, 14'h3005: feedback mask. Feedback is the XOR of `state[i]` for every set `TAPS[i]`.
- `RESET_SEED`, 14'h0001: state value at reset. Must be nonzero.
- `OUT_WIDTH`, 4: width of the drawn value. Must be ≤ `WIDTH`.
- `RANGE_MAX`, 9: largest acceptable drawn value. Must be < 2^`OUT_WIDTH`.
- `MAX_TRIES`, 64: rejections allowed before a draw falls back.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  free-run step enable.
- `seed_load`  in  1  load `seed` into the state on this edge.
- `seed`  in  WIDTH  seed value.
- `draw_req`  in  1  request a draw; sampled only in IDLE.
- `draw_busy`  out  1  high in SEARCH and HOLD.
- `rand_valid`  out  1  `rand_out` holds a completed draw.
- `rand_ready`  in  1  consumer accepts the draw.
- `rand_out`  out  OUT_WIDTH  drawn value.
- `rand_fallback`  out  1  the current draw hit `MAX_TRIES`.
- `lfsr_state`  out  WIDTH  current LFSR state.

## Operation
- Step function: `next = {state[WIDTH-2:0], fb}`, with `fb = ^(state & TAPS)`.
- State update on each edge, in priority order:
  1. `seed_load`: state ← `seed`. A zero `seed` loads 1 instead.
  2. FSM in SEARCH, or `enable` high: state ← `next`.
  3. Otherwise: state holds.
- Lockup guard: if the state is ever all-zero, the next edge loads 1, unless `seed_load` is asserted.
- Candidate value: `cand = state[OUT_WIDTH-1:0]`, taken from the pre-step state on each edge.
- FSM states and transitions:
  - IDLE: if `draw_req`, go to SEARCH and clear the try counter and `rand_fallback`.
  - SEARCH (the state steps every edge regardless of `enable`):
    - If `cand` ≤ `RANGE_MAX`: `rand_out` ← `cand`, `rand_valid` ← 1, go to HOLD.
    - Else if tries == `MAX_TRIES`-1: `rand_out` ← 0, `rand_fallback` ← 1, `rand_valid` ← 1, go to HOLD.
    - Else: increment tries.
  - HOLD: `rand_out` and `rand_fallback` are stable. If `rand_ready`, clear `rand_valid` and go to IDLE.
- `draw_req` is ignored outside IDLE.
- `seed_load` during SEARCH changes the state but leaves the FSM and try counter unaffected.
- `seed_load` during HOLD never alters `rand_out`.
- Try counter width is `$clog2(MAX_TRIES+1)`. It must not wrap.

## Timing
- Reset values:
  - state = `RESET_SEED`; FSM = IDLE
  - `rand_valid` = 0, `rand_out` = 0, `rand_fallback` = 0, `draw_busy` = 0
- `lfsr_state` is the register output itself, with zero added latency.
- Draw latency, where edge E0 samples `draw_req`:
  - `draw_busy` is high after E0.
  - Best case: `rand_valid` rises after E1, a two-edge minimum.
  - With k rejections: `rand_valid` rises after E(1+k).
  - Worst case: after E(`MAX_TRIES`).
- Handshake:
  - `rand_valid` and `rand_ready` both high on an edge transfers the value.
  - `rand_valid` falls after that edge.
  - A new `draw_req` is accepted on the following edge at the earliest.
  - `rand_ready` high before `rand_valid` has no effect.
- Reset asserted mid-SEARCH or mid-HOLD returns every register to its reset value immediately. No partial draw survives.

## Test plan
- Free-run, defaults, reset then `enable`=1: `lfsr_state` reads 0x0001, 0x0003, 0x0007, 0x000E on successive edges. With `enable`=0 the state holds.
- Zero seed: `seed_load` with `seed`=0 → `lfsr_state`=0x0001 on the next edge. `seed_load` with `enable`=1 → the loaded value wins.
- Immediate accept: load 0x0001, `enable`=0, pulse `draw_req` → `rand_valid` after the second edge, `rand_out`=1, `rand_fallback`=0. Hold `rand_ready`=0 for 5 cycles → `rand_out` is stable. Raise `rand_ready` → `rand_valid` drops and the FSM returns to IDLE.
- Rejection: load 0x000E, draw → candidates 14, 13, 10 rejected (states 0x000E, 0x001D, 0x003A), then 0x0074 accepted → `rand_out`=4 after the fifth edge.
- Fallback with `TAPS`=0 and `MAX_TRIES`=4: load 0x000F, draw → the state shifts in zeros; with `RANGE_MAX`=2, candidates 15, 14, 12, 8 are all rejected → `rand_out`=0, `rand_fallback`=1 after the fifth edge.
- Async reset asserted mid-SEARCH between edges → outputs return to reset values immediately. After release, a new draw behaves as in the immediate-accept scenario from `RESET_SEED`.

Source files
------------

// File: rtl/lfsr_random_source.sv
// Fibonacci LFSR random source: free-running state with seed loading and a zero-lockup
// guard, plus a draw engine that rejection-samples values into [0, RANGE_MAX].
module lfsr_random_source #(
  parameter int                 WIDTH      = 14,
  parameter logic [WIDTH-1:0]   TAPS       = 14'h3005,
  parameter logic [WIDTH-1:0]   RESET_SEED = 14'h0001,
  parameter int                 OUT_WIDTH  = 4,
  parameter int                 RANGE_MAX  = 9,
  parameter int                 MAX_TRIES  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_seed_load,
  input  logic [WIDTH-1:0]     i_seed,
  input  logic                 i_draw_req,
  output logic                 o_draw_busy,
  output logic                 o_rand_valid,
  input  logic                 i_rand_ready,
  output logic [OUT_WIDTH-1:0] o_rand_out,
  output logic                 o_rand_fallback,
  output logic [WIDTH-1:0]     o_lfsr_state
);

  localparam int                   TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_WIDTH-1:0] RANGE_LIM = OUT_WIDTH'(RANGE_MAX);
  localparam logic [TRY_W-1:0]     LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0]     ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } drawState_t;

  drawState_t             r_state;
  logic [WIDTH-1:0]       r_lfsrState;
  logic [TRY_W-1:0]       r_tries;
  logic [OUT_WIDTH-1:0]   r_randOut;
  logic                   r_randValid;
  logic                   r_randFallback;

  drawState_t             w_stateNext;
  logic                   w_feedback;
  logic [WIDTH-1:0]       w_lfsrStep;
  logic [WIDTH-1:0]       w_lfsrNext;
  logic [OUT_WIDTH-1:0]   w_cand;
  logic [TRY_W-1:0]       w_triesNext;
  logic [OUT_WIDTH-1:0]   w_randOutNext;
  logic                   w_randValidNext;
  logic                   w_randFallbackNext;

  assign w_feedback = ^(r_lfsrState & TAPS);
  assign w_lfsrStep = {r_lfsrState[WIDTH-2:0], w_feedback};
  assign w_cand     = r_lfsrState[OUT_WIDTH-1:0];

  // Seed load outranks the lockup guard, which outranks stepping; SEARCH steps even when disabled.
  always_comb begin
    w_lfsrNext = r_lfsrState;
    if (i_seed_load) begin
      w_lfsrNext = (i_seed == '0) ? ONE : i_seed;
    end else if (r_lfsrState == '0) begin
      w_lfsrNext = ONE;
    end else if ((r_state == SEARCH) || i_enable) begin
      w_lfsrNext = w_lfsrStep;
    end
  end

  always_comb begin
    w_stateNext        = r_state;
    w_triesNext        = r_tries;
    w_randOutNext      = r_randOut;
    w_randValidNext    = r_randValid;
    w_randFallbackNext = r_randFallback;
    case (r_state)
      IDLE: begin
        if (i_draw_req) begin
          w_stateNext        = SEARCH;
          w_triesNext        = '0;
          w_randFallbackNext = 1'b0;
        end
      end
      SEARCH: begin
        if (w_cand <= RANGE_LIM) begin
          w_randOutNext   = w_cand;
          w_randValidNext = 1'b1;
          w_stateNext     = HOLD;
        end else if (r_tries == LAST_TRY) begin
          w_randOutNext      = '0;
          w_randFallbackNext = 1'b1;
          w_randValidNext    = 1'b1;
          w_stateNext        = HOLD;
        end else begin
          w_triesNext = r_tries + TRY_W'(1);
        end
      end
      HOLD: begin
        if (i_rand_ready) begin
          w_randValidNext = 1'b0;
          w_stateNext     = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_lfsrState    <= RESET_SEED;
      r_tries        <= '0;
      r_randOut      <= '0;
      r_randValid    <= 1'b0;
      r_randFallback <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_lfsrState    <= w_lfsrNext;
      r_tries        <= w_triesNext;
      r_randOut      <= w_randOutNext;
      r_randValid    <= w_randValidNext;
      r_randFallback <= w_randFallbackNext;
    end
  end

  assign o_draw_busy     = (r_state != IDLE);
  assign o_rand_valid    = r_randValid;
  assign o_rand_out      = r_randOut;
  assign o_rand_fallback = r_randFallback;
  assign o_lfsr_state    = r_lfsrState;

endmodule
